fsm_counter_cmd_queue: RTL

//   Upstream command stage for the FSM counter. Buffers count requests in a small FIFO
//   and issues them one at a time: presents the count, pulses the run strobe, then waits
//   for the counter's done pulse. Zero counts never reach the counter; they are discarded.

---
 rtl/fsm_counter_cmd_queue_if.sv | 11 +
 rtl/fsm_counter_cmd_queue.sv | 105 ++++++++++
 2 files changed

// File: rtl/fsm_counter_cmd_queue_if.sv
// Producer-side command handshake for fsm_counter_cmd_queue.
interface fsm_counter_cmd_queue_if #(
   parameter int unsigned CNT_W = 7
);
   logic             s_valid;
   logic             s_ready;
   logic [CNT_W-1:0] s_num_cnt;

   modport master (output s_valid, output s_num_cnt, input s_ready);
   modport slave  (input s_valid, input s_num_cnt, output s_ready);
endinterface

// File: rtl/fsm_counter_cmd_queue.sv
// FIFO-buffered command issue stage for the FSM counter; zero counts are dropped.
// Define CMD_STATS_EN to add the saturating o_done_cnt completion counter.
module fsm_counter_cmd_queue #(
   parameter int unsigned CNT_W = 7,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   fsm_counter_cmd_queue_if.slave  cmd,
   output logic                    o_is_run,
   output logic [CNT_W-1:0]        o_num_cnt,
   input  logic                    i_idle,
   input  logic                    i_done,
   output logic                    o_drop,
   output logic                    o_busy,
   output logic [AW:0]             o_fifo_level
`ifdef CMD_STATS_EN
   ,
   output logic [15:0]             o_done_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      level;
   logic             zero_cnt, accept, push, pop;

   // Ready depends only on the registered level, so a same-cycle pop never frees a slot early.
   assign zero_cnt     = (cmd.s_num_cnt == '0);
   assign cmd.s_ready  = (level != FULL_LVL);
   assign accept       = cmd.s_valid & cmd.s_ready;
   assign push         = accept & ~zero_cnt;
   assign o_is_run     = (state == S_ISSUE);
   assign o_busy       = (state != S_IDLE) | (level != '0);
   assign o_fifo_level = level;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            if ((level != '0) && i_idle) begin
               state_nxt = S_ISSUE;
               pop       = 1'b1;
            end
         end
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (i_done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         o_num_cnt <= '0;
         o_drop    <= 1'b0;
      end else begin
         state  <= state_nxt;
         o_drop <= accept & zero_cnt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            o_num_cnt <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cmd.s_num_cnt;
   end

`ifdef CMD_STATS_EN
   logic [15:0] done_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         done_cnt <= '0;
      end else if ((state == S_WAIT) && i_done && (done_cnt != '1)) begin
         done_cnt <= done_cnt + 1'b1;
      end
   end

   assign o_done_cnt = done_cnt;
`endif

endmodule
